// File: rtl/snake_step_timer.sv
// Step pacing for the snake controller: sticky go request, committed heading, length and game state.
// Optional build macro SNAKE_SPEEDUP_EN shortens the step period on each eat down to TICK_MIN.
module snake_step_timer #(
  parameter int          TICK_CYCLES = 12_500_000,
  parameter logic [10:0] INIT_LEN    = 11'd4,
  parameter logic [10:0] MAX_LEN     = 11'd1024,
  parameter int          TICK_STEP   = 250_000,
  parameter int          TICK_MIN    = 2_500_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        key_up,
  input  logic        key_down,
  input  logic        key_left,
  input  logic        key_right,
  input  logic        eat,
  input  logic        collide,
  input  logic        ack,
  output logic        go,
  output logic [1:0]  dir,
  output logic [10:0] length,
  output logic        running,
  output logic        game_over
);

  localparam int CW = $clog2(TICK_CYCLES + 1);

  if (TICK_CYCLES < 2 || TICK_MIN < 2 || TICK_STEP < 0) begin : g_bad_cfg
    $error("snake_step_timer: TICK_CYCLES and TICK_MIN must be >= 2, TICK_STEP >= 0");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DEAD = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    pend_dir;
  logic [1:0]    req_dir;
  logic          key_any;
  logic          turn_ok;
  logic          tick;

`ifdef SNAKE_SPEEDUP_EN
  // period is the value for the next interval; cur_period governs the running one.
  logic [CW-1:0] period;
  logic [CW-1:0] cur_period;
  logic [CW-1:0] eat_period;

  assign eat_period = (32'(period) >= 32'(TICK_MIN + TICK_STEP))
                    ? period - CW'(TICK_STEP) : CW'(TICK_MIN);
  assign tick = (state == RUN) && (cnt == cur_period - 1'b1);
`else
  assign tick = (state == RUN) && (cnt == CW'(TICK_CYCLES - 1));
`endif

  always_comb begin
    key_any = key_up | key_down | key_left | key_right;
    req_dir = 2'b11;
    if (key_up)        req_dir = 2'b00;
    else if (key_down) req_dir = 2'b01;
    else if (key_left) req_dir = 2'b10;
  end

  // A request on the same axis but opposite sense to the committed heading is a reversal.
  assign turn_ok = key_any && !((dir[1] == req_dir[1]) && (dir[0] != req_dir[0]));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      go         <= 1'b0;
      dir        <= 2'b11;
      pend_dir   <= 2'b11;
      length     <= INIT_LEN;
      cnt        <= '0;
      running    <= 1'b0;
      game_over  <= 1'b0;
`ifdef SNAKE_SPEEDUP_EN
      period     <= CW'(TICK_CYCLES);
      cur_period <= CW'(TICK_CYCLES);
`endif
    end else begin
      case (state)
        IDLE, DEAD: begin
          if (start) begin
            state      <= RUN;
            running    <= 1'b1;
            game_over  <= 1'b0;
            go         <= 1'b0;
            dir        <= 2'b11;
            pend_dir   <= 2'b11;
            length     <= INIT_LEN;
            cnt        <= '0;
`ifdef SNAKE_SPEEDUP_EN
            period     <= CW'(TICK_CYCLES);
            cur_period <= CW'(TICK_CYCLES);
`endif
          end
        end
        RUN: begin
          if (collide) begin
            state     <= DEAD;
            running   <= 1'b0;
            game_over <= 1'b1;
            go        <= 1'b0;
          end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick)     go <= 1'b1;
            else if (ack) go <= 1'b0;
            if (tick)     dir <= pend_dir;
            if (turn_ok)  pend_dir <= req_dir;
            if (eat && (length < MAX_LEN)) length <= length + 11'd1;
`ifdef SNAKE_SPEEDUP_EN
            if (eat)  period <= eat_period;
            if (tick) cur_period <= eat ? eat_period : period;
`endif
          end
        end
        default: begin
          state     <= IDLE;
          running   <= 1'b0;
          game_over <= 1'b0;
          go        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snake_step_timer.sv
// Self-checking bench for snake_step_timer: directed scenarios plus randomized run against a countdown model.
// Honours SNAKE_SPEEDUP_EN the same way the design does.
module tb_snake_step_timer;

  localparam int TC = 8;
  localparam int IL = 4;
  localparam int ML = 6;
  localparam int ST = 2;
  localparam int MN = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0;
  logic        eat = 1'b0, collide = 1'b0, ack = 1'b0;
  logic        go;
  logic [1:0]  dir;
  logic [10:0] length;
  logic        running, game_over;

  int checks = 0;
  int errors = 0;

  // Reference model: 0 idle, 1 run, 2 dead; m_left counts down cycles to the next tick.
  int         m_state = 0;
  bit         m_go = 0;
  logic [1:0] m_dir = 2'b11, m_pend = 2'b11;
  int         m_len = IL;
  int         m_left = TC;
  int         m_next = TC;

  snake_step_timer #(
    .TICK_CYCLES(TC), .INIT_LEN(11'(IL)), .MAX_LEN(11'(ML)), .TICK_STEP(ST), .TICK_MIN(MN)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .key_up(key_up), .key_down(key_down),
    .key_left(key_left), .key_right(key_right), .eat(eat), .collide(collide), .ack(ack),
    .go(go), .dir(dir), .length(length), .running(running), .game_over(game_over)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic bit is_reverse(input logic [1:0] cur, input logic [1:0] req);
    case (cur)
      2'b00:   return req == 2'b01;
      2'b01:   return req == 2'b00;
      2'b10:   return req == 2'b11;
      default: return req == 2'b10;
    endcase
  endfunction

  task automatic model_run_entry();
    m_state = 1; m_go = 0; m_dir = 2'b11; m_pend = 2'b11;
    m_len = IL; m_left = TC; m_next = TC;
  endtask

  task automatic model_edge();
    logic [1:0] req;
    bit accept, tick;
    if (!rst) begin
      m_state = 0; m_go = 0; m_dir = 2'b11; m_pend = 2'b11;
      m_len = IL; m_left = TC; m_next = TC;
    end else if (m_state != 1) begin
      if (start) model_run_entry();
    end else if (collide) begin
      m_state = 2; m_go = 0;
    end else begin
      tick = (m_left == 1);
      req = key_up ? 2'b00 : key_down ? 2'b01 : key_left ? 2'b10 : 2'b11;
      accept = (key_up || key_down || key_left || key_right) && !is_reverse(m_dir, req);
      if (tick) m_dir = m_pend;
      if (accept) m_pend = req;
      if (eat) begin
        if (m_len < ML) m_len = m_len + 1;
`ifdef SNAKE_SPEEDUP_EN
        m_next = (m_next - ST < MN) ? MN : m_next - ST;
`endif
      end
      if (tick) begin
        m_go = 1;
        m_left = m_next;
      end else begin
        if (ack) m_go = 0;
        m_left = m_left - 1;
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  // Steps until the edge that samples a tick has passed.
  task automatic wait_tick(input string tag);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (m_state == 1 && m_left == 1 && rst && !collide) seen = 1;
      step();
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL %s tick_timeout got none, required tick within 40 cycles", tag);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step(); step();
    checks += 5;
    if (go !== 1'b0)        begin errors++; $display("[TB] FAIL reset_go got %b required 0", go); end
    if (dir !== 2'b11)      begin errors++; $display("[TB] FAIL reset_dir got %b required 11", dir); end
    if (length !== 11'(IL)) begin errors++; $display("[TB] FAIL reset_length got %0d required %0d", length, IL); end
    if (running !== 1'b0)   begin errors++; $display("[TB] FAIL reset_running got %b required 0", running); end
    if (game_over !== 1'b0) begin errors++; $display("[TB] FAIL reset_game_over got %b required 0", game_over); end
    rst = 1'b1;
    step();
  endtask

  task automatic test_go_timing();
    bit early = 0;
    bit dropped = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (running !== 1'b1) begin errors++; $display("[TB] FAIL start_running got %b required 1", running); end
    for (int i = 1; i < TC; i++) begin
      step();
      if (go !== 1'b0) early = 1;
    end
    checks++;
    if (early) begin errors++; $display("[TB] FAIL go_early got 1 before cycle %0d required 0", TC); end
    step();
    checks++;
    if (go !== 1'b1) begin errors++; $display("[TB] FAIL go_rise got %b required 1 at cycle %0d", go, TC); end
    for (int i = 0; i < TC + 2; i++) begin
      step();
      if (go !== 1'b1) dropped = 1;
    end
    checks++;
    if (dropped) begin errors++; $display("[TB] FAIL go_hold got 0 required 1 while ack low"); end
  endtask

  task automatic test_ack();
    for (int i = 0; i < 40 && m_left != 1; i++) step();
    ack = 1'b1;
    step();
    ack = 1'b0;
    checks++;
    if (go !== 1'b1) begin errors++; $display("[TB] FAIL ack_with_tick got %b required 1", go); end
    step(); step();
    ack = 1'b1;
    step();
    ack = 1'b0;
    checks++;
    if (go !== 1'b0) begin errors++; $display("[TB] FAIL ack_alone got %b required 0", go); end
  endtask

  task automatic test_heading();
    wait_tick("heading_align");
    key_left = 1'b1;
    step();
    key_left = 1'b0;
    wait_tick("heading_rev");
    checks++;
    if (dir !== 2'b11) begin errors++; $display("[TB] FAIL reverse_ignored got %b required 11", dir); end
    key_up = 1'b1;
    step();
    key_up = 1'b0;
    key_left = 1'b1;
    step();
    wait_tick("heading_up");
    checks++;
    if (dir !== 2'b00) begin errors++; $display("[TB] FAIL turn_up got %b required 00", dir); end
    wait_tick("heading_left");
    key_left = 1'b0;
    checks++;
    if (dir !== 2'b10) begin errors++; $display("[TB] FAIL turn_left got %b required 10", dir); end
  endtask

  task automatic test_length();
    int exp_len[3] = '{5, 6, 6};
    for (int i = 0; i < 3; i++) begin
      eat = 1'b1;
      step();
      eat = 1'b0;
      checks++;
      if (length !== 11'(exp_len[i])) begin
        errors++; $display("[TB] FAIL eat_%0d got %0d required %0d", i, length, exp_len[i]);
      end
    end
    rst = 1'b0;
    step();
    rst = 1'b1;
    checks += 2;
    if (go !== 1'b0)        begin errors++; $display("[TB] FAIL midstep_reset_go got %b required 0", go); end
    if (length !== 11'(IL)) begin errors++; $display("[TB] FAIL midstep_reset_len got %0d required %0d", length, IL); end
    eat = 1'b1;
    step();
    eat = 1'b0;
    checks++;
    if (length !== 11'(IL)) begin errors++; $display("[TB] FAIL idle_eat got %0d required %0d", length, IL); end
  endtask

  task automatic test_dead_restart();
    bit moved = 0;
    start = 1'b1; step(); start = 1'b0;
    key_up = 1'b1; step(); key_up = 1'b0;
    eat = 1'b1; step(); eat = 1'b0;
    wait_tick("dead_align");
    collide = 1'b1;
    step();
    collide = 1'b0;
    checks += 3;
    if (game_over !== 1'b1) begin errors++; $display("[TB] FAIL collide_game_over got %b required 1", game_over); end
    if (running !== 1'b0)   begin errors++; $display("[TB] FAIL collide_running got %b required 0", running); end
    if (go !== 1'b0)        begin errors++; $display("[TB] FAIL collide_go got %b required 0", go); end
    eat = 1'b1; step(); eat = 1'b0;
    for (int i = 0; i < 2 * TC; i++) begin
      step();
      if (go !== 1'b0 || game_over !== 1'b1 || length !== 11'(IL + 1)) moved = 1;
    end
    checks++;
    if (moved) begin errors++; $display("[TB] FAIL dead_frozen got activity in DEAD required none"); end
    start = 1'b1; step(); start = 1'b0;
    checks += 4;
    if (running !== 1'b1)   begin errors++; $display("[TB] FAIL restart_running got %b required 1", running); end
    if (length !== 11'(IL)) begin errors++; $display("[TB] FAIL restart_len got %0d required %0d", length, IL); end
    if (dir !== 2'b11)      begin errors++; $display("[TB] FAIL restart_dir got %b required 11", dir); end
    if (game_over !== 1'b0) begin errors++; $display("[TB] FAIL restart_game_over got %b required 0", game_over); end
    moved = 0;
    for (int i = 1; i < TC; i++) begin
      step();
      if (go !== 1'b0) moved = 1;
    end
    step();
    checks++;
    if (moved || go !== 1'b1) begin errors++; $display("[TB] FAIL restart_first_go got %b required 1 at cycle %0d", go, TC); end
    collide = 1'b1; start = 1'b1;
    step();
    collide = 1'b0; start = 1'b0;
    checks++;
    if (game_over !== 1'b1 || running !== 1'b0) begin
      errors++; $display("[TB] FAIL collide_beats_start got game_over=%b running=%b required 1 0", game_over, running);
    end
  endtask

  task automatic test_speedup();
    int t;
`ifdef SNAKE_SPEEDUP_EN
    int exp_gap[4] = '{8, 6, 4, 4};
`else
    int exp_gap[4] = '{8, 8, 8, 8};
`endif
    start = 1'b1; step(); start = 1'b0;
    ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      eat = (k < 3);
      step();
      eat = 1'b0;
      t = 1;
      while (go !== 1'b1 && t < 30) begin
        step();
        t++;
      end
      checks++;
      if (t != exp_gap[k]) begin
        errors++; $display("[TB] FAIL tick_gap_%0d got %0d cycles required %0d", k, t, exp_gap[k]);
      end
    end
    ack = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      rst       = ($urandom_range(0, 199) != 0);
      start     = ($urandom_range(0, 39) == 0);
      key_up    = ($urandom_range(0, 5) == 0);
      key_down  = ($urandom_range(0, 5) == 0);
      key_left  = ($urandom_range(0, 5) == 0);
      key_right = ($urandom_range(0, 5) == 0);
      eat       = ($urandom_range(0, 7) == 0);
      collide   = ($urandom_range(0, 69) == 0);
      ack       = ($urandom_range(0, 2) == 0);
      step();
      checks += 5;
      if (go !== m_go) begin errors++; $display("[TB] FAIL rnd_go cyc %0d got %b required %b", i, go, m_go); end
      if (dir !== m_dir) begin errors++; $display("[TB] FAIL rnd_dir cyc %0d got %b required %b", i, dir, m_dir); end
      if (length !== 11'(m_len)) begin errors++; $display("[TB] FAIL rnd_len cyc %0d got %0d required %0d", i, length, m_len); end
      if (running !== (m_state == 1)) begin errors++; $display("[TB] FAIL rnd_running cyc %0d got %b required %b", i, running, m_state == 1); end
      if (game_over !== (m_state == 2)) begin errors++; $display("[TB] FAIL rnd_game_over cyc %0d got %b required %b", i, game_over, m_state == 2); end
    end
    rst = 1'b1; start = 1'b0; key_up = 1'b0; key_down = 1'b0; key_left = 1'b0; key_right = 1'b0;
    eat = 1'b0; collide = 1'b0; ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_go_timing();
    test_ack();
    test_heading();
    test_length();
    test_dead_restart();
    test_speedup();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
